// File: rtl/pcileech_mux_sched_pkg.sv
// Shared definitions for the PCILeech multiplexer scheduler: FSM states,
// port count, frame geometry and the filler word value.
package pcileech_mux_sched_pkg;

    localparam int          NUM_PORTS   = 4;
    localparam int          FRAME_WORDS = 7;
    localparam logic [31:0] PAD_WORD    = 32'hffff_ffff;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/pcileech_mux_arb4.sv
// Four-way combinational arbiter: the lowest-numbered request at or after
// ptr (wrapping) wins; ptr = 0 gives fixed priority with port 0 highest.
module pcileech_mux_arb4
    import pcileech_mux_sched_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [1:0]           winner,
    output logic                 valid
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [1:0]             off;

    // Rotate so the pointer position becomes bit 0, then pick the lowest set bit.
    assign dbl = {req, req};
    assign rot = dbl[{1'b0, ptr} +: NUM_PORTS];

    always_comb begin
        off = 2'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
    end

    assign winner = ptr + off;
    assign valid  = |req;

endmodule

// File: rtl/pcileech_mux_sched.sv
// Read scheduler for the 4-port PCILeech mux: burst grants, drain gap and
// partial-frame padding. Define PCILEECH_MUX_SCHED_RR_EN for round-robin.
module pcileech_mux_sched
    import pcileech_mux_sched_pkg::*;
#(
    parameter int BURST_MAX     = 7,
    parameter int DRAIN_CYCLES  = 2,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [NUM_PORTS-1:0] has_data,
    input  logic [NUM_PORTS-1:0] wr_en,
    output logic [NUM_PORTS-1:0] req_data,
    output logic [1:0]           grant_id,
    output logic                 pad_req,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int IDLE_W  = $clog2(FLUSH_TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [2:0]         frame_cnt;
    logic [1:0]         arb_ptr, arb_winner;
    logic               arb_valid;
    logic               pad_issue, beat, frame_wrap, flush_due, burst_end;

    pcileech_mux_arb4 u_arb (
        .req    (has_data),
        .ptr    (arb_ptr),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

`ifdef PCILEECH_MUX_SCHED_RR_EN
    logic [1:0] rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 2'd0;
        else if (state == ST_IDLE && state_nxt == ST_GRANT)
            rr_ptr <= arb_winner + 2'd1;
    end

    assign arb_ptr = rr_ptr;
`else
    assign arb_ptr = 2'd0;
`endif

    // A beat from a source suppresses the pad, so a word is never counted twice.
    assign pad_issue  = (state == ST_FLUSH) && !(|wr_en);
    assign beat       = (|wr_en) || pad_issue;
    assign frame_wrap = beat && (frame_cnt == 3'(FRAME_WORDS - 1));
    assign flush_due  = (idle_cnt == IDLE_W'(FLUSH_TIMEOUT)) && (frame_cnt != 3'd0);
    assign burst_end  = (burst_cnt == BURST_W'(BURST_MAX)) || !has_data[grant_id];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush_due)
                    state_nxt = ST_FLUSH;
                else if (rd_en && arb_valid)
                    state_nxt = ST_GRANT;
            end
            ST_GRANT: if (burst_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_nxt = ST_IDLE;
            ST_FLUSH: if (frame_wrap) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_data   <= '0;
            grant_id   <= 2'd0;
            pad_req    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            burst_cnt  <= '0;
            drain_cnt  <= '0;
            idle_cnt   <= '0;
            frame_cnt  <= 3'd0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != ST_IDLE);
            pad_req    <= pad_issue;
            frame_done <= frame_wrap;
            drain_cnt  <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            req_data   <= '0;

            if (beat)
                frame_cnt <= frame_wrap ? 3'd0 : frame_cnt + 3'd1;

            if (beat)
                idle_cnt <= '0;
            else if (frame_cnt != 3'd0 && idle_cnt != IDLE_W'(FLUSH_TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_GRANT) begin
                        grant_id  <= arb_winner;
                        burst_cnt <= '0;
                    end
                end
                // rd_en low only pauses the burst; state and count are held.
                ST_GRANT: begin
                    if (!burst_end && rd_en) begin
                        req_data  <= NUM_PORTS'(1) << grant_id;
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_mux_sched.sv
// Randomized and directed bench for pcileech_mux_sched against a behavioural
// model of the scheduling rules; honours PCILEECH_MUX_SCHED_RR_EN.
module tb_pcileech_mux_sched;
    import pcileech_mux_sched_pkg::*;

    localparam int BURST = 7;
    localparam int DRAIN = 2;
    localparam int FLUSH_T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] has_data = 4'd0;
    logic [3:0] wr_en = 4'd0;
    logic [3:0] req_data;
    logic [1:0] grant_id;
    logic       pad_req, frame_done, busy;

    pcileech_mux_sched #(
        .BURST_MAX     (BURST),
        .DRAIN_CYCLES  (DRAIN),
        .FLUSH_TIMEOUT (FLUSH_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .has_data   (has_data),
        .wr_en      (wr_en),
        .req_data   (req_data),
        .grant_id   (grant_id),
        .pad_req    (pad_req),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: modes, words-in-frame, quiet cycles, requests issued.
    typedef enum {M_IDLE, M_GRANT, M_DRAIN, M_FLUSH} mode_e;
    mode_e      m_mode;
    int         m_gid, m_start, m_issued, m_drain_left, m_words, m_quiet;
    logic [3:0] m_req;
    bit         m_pad, m_done, m_busy;

    logic [3:0] src_we = 4'd0;
    bit         prev_busy = 1'b0;
    int         gseq[$];

    function automatic int pick(input logic [3:0] hd, input int start);
        for (int k = 0; k < 4; k++) begin
            if (hd[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_gid = 0; m_start = 0; m_issued = 0; m_drain_left = 0;
        m_words = 0; m_quiet = 0; m_req = 4'd0; m_pad = 0; m_done = 0; m_busy = 0;
    endtask

    task automatic model_edge(input bit rd, input logic [3:0] hd, input logic [3:0] we);
        bit pad_now, beat_now, wrap;
        pad_now  = (m_mode == M_FLUSH) && (we == 4'd0);
        beat_now = (we != 4'd0) || pad_now;
        wrap     = beat_now && ((m_words + 1) % FRAME_WORDS == 0);
        m_pad  = pad_now;
        m_done = wrap;
        m_req  = 4'd0;
        case (m_mode)
            M_IDLE: begin
                if (m_quiet == FLUSH_T && m_words != 0) begin
                    m_mode = M_FLUSH;
                end else if (rd && hd != 4'd0) begin
                    m_gid = pick(hd, m_start);
                    m_issued = 0;
                    m_mode = M_GRANT;
`ifdef PCILEECH_MUX_SCHED_RR_EN
                    m_start = (m_gid + 1) % 4;
`endif
                end
            end
            M_GRANT: begin
                if (m_issued == BURST || !hd[m_gid]) begin
                    m_mode = M_DRAIN;
                    m_drain_left = DRAIN;
                end else if (rd) begin
                    m_req = 4'd1 << m_gid;
                    m_issued++;
                end
            end
            M_DRAIN: begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = M_IDLE;
            end
            M_FLUSH: if (wrap) m_mode = M_IDLE;
        endcase
        if (beat_now) m_quiet = 0;
        else if (m_words != 0 && m_quiet < FLUSH_T) m_quiet++;
        if (beat_now) m_words = (m_words + 1) % FRAME_WORDS;
        m_busy = (m_mode != M_IDLE);
    endtask

    // One clock: the source answers each request with a beat one cycle later.
    task automatic step(input bit rd, input logic [3:0] hd, input logic [3:0] xwe);
        @(negedge clk);
        rd_en = rd;
        has_data = hd;
        wr_en = src_we | xwe;
        src_we = m_req;
        @(posedge clk);
        model_edge(rd, hd, wr_en);
        #1;
        chk("req_data", req_data, m_req);
        chk("grant_id", grant_id, m_gid);
        chk("pad_req", pad_req, m_pad);
        chk("frame_done", frame_done, m_done);
        chk("busy", busy, m_busy);
        if (busy && !prev_busy) gseq.push_back(grant_id);
        prev_busy = busy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_data", req_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_pad_req", pad_req, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        src_we = 4'd0; rd_en = 1'b0; has_data = 4'd0; wr_en = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic test_single_port();
        int n_req = 0, tail = 0, n_done = 0, guard = 0;
        bool_seen: begin end
        do_reset();
        gseq.delete();
        do begin
            step(1'b1, 4'b0010, 4'd0);
            if (req_data == 4'b0010) n_req++;
            if (busy && req_data == 4'd0 && n_req > 0) tail++;
            if (frame_done) n_done++;
            guard++;
        end while (!(n_req > 0 && !busy) && guard < 40);
        chk("t034_req_cycles", n_req, 7);
        chk("t034_drain_cycles", tail, 2);
        chk("t034_frame_done", n_done, 1);
        chk("t034_gid", (gseq.size() > 0) ? gseq[0] : 99, 1);
    endtask

    task automatic test_grant_order();
        int guard = 0;
        do_reset();
        gseq.delete();
        while (gseq.size() < 5 && guard < 120) begin
            step(1'b1, 4'b1111, 4'd0);
            guard++;
        end
        chk("t035_grants", gseq.size() >= 5, 1);
`ifdef PCILEECH_MUX_SCHED_RR_EN
        for (int i = 0; i < 5 && i < gseq.size(); i++) chk("t035_rr_gid", gseq[i], i % 4);
`else
        for (int i = 0; i < 3 && i < gseq.size(); i++) chk("t035_fixed_gid", gseq[i], 0);
`endif
    endtask

    // Partial frame of three words times out and gets padded; optionally a
    // source beat lands in the second flush cycle.
    task automatic test_flush(input bit inject);
        int n_pad = 0, n_done = 0, guard = 0, fl = 0;
        bit seen_busy = 0;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 4'b0001);
        while (!(seen_busy && !busy) && guard < 60) begin
            step(1'b1, 4'd0, (inject && fl == 2) ? 4'b0100 : 4'd0);
            if (busy) seen_busy = 1;
            if (seen_busy) fl++;
            if (inject && fl == 3) chk("t039_pad_low_on_beat", pad_req, 0);
            if (pad_req) n_pad++;
            if (frame_done) n_done++;
            guard++;
        end
        step(1'b1, 4'd0, 4'd0);
        if (pad_req) n_pad++;
        chk(inject ? "t039_pad_cycles" : "t036_pad_cycles", n_pad, inject ? 3 : 4);
        chk(inject ? "t039_frame_done" : "t036_frame_done", n_done, 1);
        chk("t036_flush_seen", seen_busy, 1);
        chk("t036_back_idle", busy, 0);
    endtask

    task automatic test_rd_gap();
        int n_req = 0, gap_req = 0, guard = 0;
        do_reset();
        while (n_req < 3 && guard < 20) begin
            step(1'b1, 4'b0001, 4'd0);
            if (req_data != 4'd0) n_req++;
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0001, 4'd0);
            if (req_data != 4'd0) gap_req++;
        end
        guard = 0;
        while (busy && guard < 40) begin
            step(1'b1, 4'b0001, 4'd0);
            if (req_data != 4'd0) n_req++;
            guard++;
        end
        chk("t037_gap_req", gap_req, 0);
        chk("t037_total_req", n_req, 7);
    endtask

    task automatic test_reset_in_flush();
        int guard = 0, n_pad = 0, n_done = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 4'd0, 4'b1000);
        while (!busy && guard < 40) begin
            step(1'b1, 4'd0, 4'd0);
            guard++;
        end
        chk("t038_in_flush", busy, 1);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 4'd0, 4'd0);
            if (pad_req || busy) n_pad++;
        end
        chk("t038_no_pad", n_pad, 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 4'd0, 4'b0010);
            if (frame_done) n_done++;
        end
        chk("t038_fresh_frame", n_done, 1);
    endtask

    task automatic run_random(input int cycles);
        int done_cyc = 0;
        while (done_cyc < cycles) begin
            int len = $urandom_range(8, 40);
            int mode = $urandom_range(0, 2);
            logic [3:0] seg_hd = 4'($urandom);
            for (int j = 0; j < len; j++) begin
                bit rd = ($urandom_range(0, 99) < 85);
                logic [3:0] hd = (mode == 0) ? 4'd0 : (mode == 1) ? 4'($urandom) : seg_hd;
                logic [3:0] x = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
                if ($urandom_range(0, 499) == 0) do_reset();
                else step(rd, hd, x);
                done_cyc++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_single_port();
        test_grant_order();
        test_flush(1'b0);
        test_flush(1'b1);
        test_rd_gap();
        test_reset_in_flush();
        do_reset();
        run_random(2500);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
